// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// PC generation and instruction-memory fetch stage. It issues word reads over
// a req/ack handshake, buffers returned words in a 2-entry prefetch queue, and
// presents the queue head to the fetch/decode pipeline register.
//
// Optional build macro: FETCH_HALT_EN
//   Defined   -> a fetched 32'hFFFF_FFFF stops further requests (HALT state)
//                and the extra output `halted` is present.
//   Undefined -> every word is fetched alike; no `halted` port.
//
// state | meaning
// ------+--------------------------------------------------------------
// REQ   | request outstanding at pc (req held, address stable until ack)
// HOLD  | queue has no room for another word; request lowered
// DROP  | redirect arrived mid-request; wait out the stale ack, then
//       | restart at the latched target
// HALT  | (FETCH_HALT_EN only) halt word fetched; no more requests
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4,
  parameter logic [1:0]  QDEPTH   = 2'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jmp_en,
  input  logic [31:0] jmp_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
`ifdef FETCH_HALT_EN
  ,
  output logic        halted
`endif
);

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;
`ifdef FETCH_HALT_EN
  localparam logic [1:0]  ST_HALT   = 2'd3;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
`endif

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic        req_q, req_d;

  // Queue: entry 0 is always the head, entry 1 the younger word.
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] e0_pc_q, e0_pc_d;
  logic [31:0] e0_ins_q, e0_ins_d;
  logic [31:0] e1_pc_q, e1_pc_d;
  logic [31:0] e1_ins_q, e1_ins_d;

  logic        ack_live;
  logic        push;
  logic        pop;
  logic        credit;

  // An ack only counts while our own request is up; this also discards any
  // ack belonging to a request abandoned by reset.
  assign ack_live = imem_ack & req_q;
  assign push     = ack_live & (state_q == ST_REQ) & ~jmp_en;
  assign pop      = (cnt_q != 2'd0) & ~stall & ~jmp_en;

  // Room for another word once this cycle's push/pop has settled.
  assign credit   = (cnt_d < QDEPTH);

  // Prefetch queue next-state: flush on redirect, otherwise FIFO push/pop.
  always_comb begin
    cnt_d    = cnt_q;
    e0_pc_d  = e0_pc_q;
    e0_ins_d = e0_ins_q;
    e1_pc_d  = e1_pc_q;
    e1_ins_d = e1_ins_q;
    if (jmp_en) begin
      cnt_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b11: begin
          if (cnt_q == 2'd1) begin
            e0_pc_d  = pc_q;
            e0_ins_d = imem_rdata;
          end else begin
            e0_pc_d  = e1_pc_q;
            e0_ins_d = e1_ins_q;
            e1_pc_d  = pc_q;
            e1_ins_d = imem_rdata;
          end
        end
        2'b10: begin
          if (cnt_q == 2'd0) begin
            e0_pc_d  = pc_q;
            e0_ins_d = imem_rdata;
          end else begin
            e1_pc_d  = pc_q;
            e1_ins_d = imem_rdata;
          end
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          e0_pc_d  = e1_pc_q;
          e0_ins_d = e1_ins_q;
          cnt_d    = cnt_q - 2'd1;
        end
        default: begin
          cnt_d = cnt_q;
        end
      endcase
    end
  end

  // Fetch FSM next-state: redirect first, then per-state sequencing.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    if (jmp_en) begin
      if (state_q == ST_DROP) begin
        // A stale ack landing with a fresh redirect ends the drop right away.
        if (ack_live) begin
          state_d = ST_REQ;
          pc_d    = jmp_target;
        end else begin
          tgt_d = jmp_target;
        end
      end else if ((state_q == ST_REQ) && req_q && !imem_ack) begin
        // The in-flight read must still complete; keep its address on the bus.
        state_d = ST_DROP;
        tgt_d   = jmp_target;
      end else begin
        state_d = ST_REQ;
        pc_d    = jmp_target;
      end
    end else begin
      case (state_q)
        ST_REQ: begin
          if (ack_live) begin
            pc_d = pc_q + PC_STEP;
`ifdef FETCH_HALT_EN
            if (imem_rdata == HALT_WORD) begin
              state_d = ST_HALT;
            end else begin
              state_d = credit ? ST_REQ : ST_HOLD;
            end
`else
            state_d = credit ? ST_REQ : ST_HOLD;
`endif
          end
        end
        ST_HOLD: begin
          if (credit) begin
            state_d = ST_REQ;
          end
        end
        ST_DROP: begin
          if (ack_live) begin
            state_d = ST_REQ;
            pc_d    = tgt_q;
          end
        end
`ifdef FETCH_HALT_EN
        ST_HALT: begin
          state_d = ST_HALT;
        end
`endif
        default: begin
          state_d = ST_REQ;
        end
      endcase
    end
    // Request is registered so it is low in reset and the cycle after it.
    req_d = (state_d == ST_REQ) || (state_d == ST_DROP);
  end

  // FSM, PC and request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_REQ;
      pc_q    <= RESET_PC;
      tgt_q   <= RESET_PC;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      req_q   <= req_d;
    end
  end

  // Queue storage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= 2'd0;
      e0_pc_q  <= 32'd0;
      e0_ins_q <= 32'd0;
      e1_pc_q  <= 32'd0;
      e1_ins_q <= 32'd0;
    end else begin
      cnt_q    <= cnt_d;
      e0_pc_q  <= e0_pc_d;
      e0_ins_q <= e0_ins_d;
      e1_pc_q  <= e1_pc_d;
      e1_ins_q <= e1_ins_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign if_valid  = (cnt_q != 2'd0);
  assign if_pc     = e0_pc_q;
  assign if_instr  = e0_ins_q;

`ifdef FETCH_HALT_EN
  assign halted = (state_q == ST_HALT);
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed scenarios plus a randomized run
// against a program-order model (consumed PCs must follow pc, pc+4, ...,
// restarting at each jump target; each word must equal the memory image).
module tb_instr_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        jmp_en;
  logic [31:0] jmp_target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
`ifdef FETCH_HALT_EN
  logic        halted;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] halt_addr = 32'h0000_0001;
  int unsigned cur_wait  = 0;
  int unsigned max_wait  = 0;
  int unsigned wcnt      = 0;
  bit          rand_waits = 1'b0;

  instr_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .jmp_en     (jmp_en),
    .jmp_target (jmp_target),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_instr   (if_instr)
`ifdef FETCH_HALT_EN
    ,
    .halted     (halted)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == halt_addr) return 32'hFFFF_FFFF;
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  // Memory responder: acks after cur_wait idle cycles of an asserted request.
  task automatic mem_drive();
    if (rst || !imem_req) begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      wcnt       = 0;
    end else if (wcnt >= cur_wait) begin
      imem_ack   = 1'b1;
      imem_rdata = mem_word(imem_addr);
      wcnt       = 0;
      cur_wait   = rand_waits ? $urandom_range(0, max_wait) : max_wait;
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      wcnt       = wcnt + 1;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    jmp_en = 1'b0;
    mem_drive();
  endtask

  task automatic set_waits(input int unsigned w, input bit r);
    max_wait   = w;
    cur_wait   = w;
    rand_waits = r;
    wcnt       = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; jmp_en = 1'b0; jmp_target = 32'd0; imem_ack = 1'b0;
    wcnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; jmp_en = 1'b0; jmp_target = 32'd0;
    imem_ack = 1'b0; imem_rdata = 32'd0;
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
    n_checks++; if (imem_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_addr: got %h want %h", imem_addr, RESET_PC); end
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", if_valid); end
    n_checks++; if (if_pc !== 32'd0) begin n_fail++; $display("FAIL reset_if_pc: got %h want 0", if_pc); end
    n_checks++; if (if_instr !== 32'd0) begin n_fail++; $display("FAIL reset_if_instr: got %h want 0", if_instr); end
`ifdef FETCH_HALT_EN
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
`endif
    repeat (2) cyc();
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req_held: got %b want 0", imem_req); end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] exp;
    bit found;
    set_waits(0, 1'b0);
    halt_addr = 32'h1;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc();
      if (if_valid) found = 1'b1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL stream_first_valid: got none want valid within 20 cycles"); end
    exp = RESET_PC;
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (if_valid !== 1'b1 || if_pc !== exp) begin n_fail++; $display("FAIL stream_pc[%0d]: got v=%b pc=%h want v=1 pc=%h", k, if_valid, if_pc, exp); end
      n_checks++; if (if_instr !== mem_word(exp)) begin n_fail++; $display("FAIL stream_instr[%0d]: got %h want %h", k, if_instr, mem_word(exp)); end
      exp = exp + 32'd4;
      cyc();
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp;
    bit found;
    set_waits(0, 1'b0);
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc();
      if (if_valid) found = 1'b1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL stall_first_valid: got none want valid within 20 cycles"); end
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      n_checks++; if (if_valid !== 1'b1 || if_pc !== RESET_PC) begin n_fail++; $display("FAIL stall_hold_pc[%0d]: got v=%b pc=%h want v=1 pc=%h", k, if_valid, if_pc, RESET_PC); end
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req_low[%0d]: got %b want 0", k, imem_req); end
    end
    cyc();
    stall = 1'b0;
    exp = RESET_PC;
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (if_valid !== 1'b1 || if_pc !== exp || if_instr !== mem_word(exp)) begin n_fail++; $display("FAIL stall_release[%0d]: got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h", k, if_valid, if_pc, if_instr, exp, mem_word(exp)); end
      exp = exp + 32'd4;
      cyc();
    end
  endtask

  task automatic test_jump_wait();
    bit found;
    set_waits(3, 1'b0);
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc();
      if (imem_req && imem_addr == 32'h8) found = 1'b1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL jwait_req8: got none want req at 0x8"); end
    cyc();
    jmp_en = 1'b1; jmp_target = 32'h100;
    cyc();
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL jwait_flush: got v=%b want 0", if_valid); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_fail++; $display("FAIL jwait_stale_hold: got req=%b addr=%h want req=1 addr=00000008", imem_req, imem_addr); end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (if_valid) found = 1'b1;
      if (imem_req && imem_addr != 32'h8) found = 1'b1;
      else cyc();
    end
    n_checks++; if (!found || imem_addr !== 32'h100 || if_valid !== 1'b0) begin n_fail++; $display("FAIL jwait_next_addr: got addr=%h v=%b want addr=00000100 v=0", imem_addr, if_valid); end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (if_valid) found = 1'b1;
      else cyc();
    end
    n_checks++; if (!found || if_pc !== 32'h100 || if_instr !== mem_word(32'h100)) begin n_fail++; $display("FAIL jwait_first_valid: got v=%b pc=%h ins=%h want pc=00000100 ins=%h", if_valid, if_pc, if_instr, mem_word(32'h100)); end
  endtask

  task automatic test_jump_ack();
    bit found;
    set_waits(0, 1'b0);
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc();
      if (imem_req && imem_addr == 32'hC) found = 1'b1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL jack_reqC: got none want req at 0xC"); end
    jmp_en = 1'b1; jmp_target = 32'h40;
    cyc();
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin n_fail++; $display("FAIL jack_next_addr: got req=%b addr=%h want req=1 addr=00000040", imem_req, imem_addr); end
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL jack_flush: got v=%b want 0", if_valid); end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (if_valid) found = 1'b1;
      else cyc();
    end
    n_checks++; if (!found || if_pc !== 32'h40 || if_instr !== mem_word(32'h40)) begin n_fail++; $display("FAIL jack_first_valid: got v=%b pc=%h ins=%h want pc=00000040 ins=%h", if_valid, if_pc, if_instr, mem_word(32'h40)); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp;
    bit found;
    set_waits(0, 1'b0);
    do_reset();
    repeat (3) cyc();
    jmp_en = 1'b1; jmp_target = 32'hFFFF_FFF8;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc();
      if (if_valid) found = 1'b1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL wrap_first_valid: got none want valid within 20 cycles"); end
    exp = 32'hFFFF_FFF8;
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (if_valid !== 1'b1 || if_pc !== exp || if_instr !== mem_word(exp)) begin n_fail++; $display("FAIL wrap_seq[%0d]: got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h", k, if_valid, if_pc, if_instr, exp, mem_word(exp)); end
      exp = exp + 32'd4;
      cyc();
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    set_waits(3, 1'b0);
    do_reset();
    stall = 1'b1;
    repeat (6) cyc();
    rst = 1'b1;
    imem_ack = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b0 || imem_addr !== RESET_PC) begin n_fail++; $display("FAIL rmid_req: got req=%b addr=%h want req=0 addr=%h", imem_req, imem_addr, RESET_PC); end
    n_checks++; if (if_valid !== 1'b0 || if_pc !== 32'd0 || if_instr !== 32'd0) begin n_fail++; $display("FAIL rmid_out: got v=%b pc=%h ins=%h want all 0", if_valid, if_pc, if_instr); end
    repeat (2) cyc();
    rst = 1'b0; stall = 1'b0;
    set_waits(0, 1'b0);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc();
      if (if_valid) found = 1'b1;
    end
    n_checks++; if (!found || if_pc !== RESET_PC || if_instr !== mem_word(RESET_PC)) begin n_fail++; $display("FAIL rmid_resume: got v=%b pc=%h ins=%h want pc=%h ins=%h", if_valid, if_pc, if_instr, RESET_PC, mem_word(RESET_PC)); end
    cyc();
    n_checks++; if (if_valid !== 1'b1 || if_pc !== RESET_PC + 32'd4) begin n_fail++; $display("FAIL rmid_next: got v=%b pc=%h want v=1 pc=%h", if_valid, if_pc, RESET_PC + 32'd4); end
  endtask

`ifdef FETCH_HALT_EN
  task automatic test_halt();
    logic [31:0] exp;
    bit viol;
    bit found;
    int cnt;
    set_waits(0, 1'b0);
    halt_addr = 32'h10;
    do_reset();
    exp = RESET_PC; viol = 1'b0; cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (imem_req && imem_addr > 32'h10) viol = 1'b1;
      if (if_valid) begin
        n_checks++; if (if_pc !== exp || if_instr !== mem_word(exp)) begin n_fail++; $display("FAIL halt_drain[%0d]: got pc=%h ins=%h want pc=%h ins=%h", cnt, if_pc, if_instr, exp, mem_word(exp)); end
        exp = exp + 32'd4;
        cnt++;
      end
    end
    n_checks++; if (viol) begin n_fail++; $display("FAIL halt_no_req: got req beyond 0x10 want none"); end
    n_checks++; if (cnt != 5) begin n_fail++; $display("FAIL halt_count: got %0d want 5", cnt); end
    n_checks++; if (halted !== 1'b1 || if_valid !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL halt_state: got halted=%b v=%b req=%b want 1 0 0", halted, if_valid, imem_req); end
    halt_addr = 32'h1;
    jmp_en = 1'b1; jmp_target = 32'h0;
    cyc();
    n_checks++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL halt_restart: got halted=%b req=%b addr=%h want 0 1 00000000", halted, imem_req, imem_addr); end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (if_valid) found = 1'b1;
      else cyc();
    end
    n_checks++; if (!found || if_pc !== 32'h0) begin n_fail++; $display("FAIL halt_restart_valid: got v=%b pc=%h want v=1 pc=00000000", if_valid, if_pc); end
  endtask
`else
  task automatic test_halt_word_plain();
    logic [31:0] exp;
    set_waits(0, 1'b0);
    halt_addr = 32'h10;
    do_reset();
    exp = RESET_PC;
    for (int i = 0; i < 20 && exp < 32'h1C; i++) begin
      cyc();
      if (if_valid) begin
        n_checks++; if (if_pc !== exp || if_instr !== mem_word(exp)) begin n_fail++; $display("FAIL plain_word: got pc=%h ins=%h want pc=%h ins=%h", if_pc, if_instr, exp, mem_word(exp)); end
        exp = exp + 32'd4;
      end
    end
    n_checks++; if (exp !== 32'h1C) begin n_fail++; $display("FAIL plain_continue: got next pc %h want 0000001c", exp); end
    halt_addr = 32'h1;
  endtask
`endif

  task automatic test_random();
    logic [31:0] exp_pc, prev_pc, prev_ins, prev_addr;
    bit prev_hold, prev_out, prev_jmp;
    int consumed;
    set_waits(3, 1'b1);
    halt_addr = 32'h1;
    do_reset();
    exp_pc = RESET_PC; consumed = 0;
    prev_hold = 1'b0; prev_out = 1'b0; prev_jmp = 1'b0;
    prev_pc = 32'd0; prev_ins = 32'd0; prev_addr = 32'd0;
    for (int c = 0; c < 1500; c++) begin
      cyc();
      if (prev_jmp) begin
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_flush@%0d: got v=%b want 0", c, if_valid); end
      end else if (prev_hold) begin
        n_checks++; if (if_valid !== 1'b1 || if_pc !== prev_pc || if_instr !== prev_ins) begin n_fail++; $display("FAIL rnd_stall_hold@%0d: got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h", c, if_valid, if_pc, if_instr, prev_pc, prev_ins); end
      end
      if (prev_out) begin
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin n_fail++; $display("FAIL rnd_addr_stable@%0d: got req=%b addr=%h want req=1 addr=%h", c, imem_req, imem_addr, prev_addr); end
      end
      stall  = ($urandom_range(0, 9) < 3);
      jmp_en = ($urandom_range(0, 99) < 4);
      if (jmp_en) jmp_target = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      if (if_valid && !stall && !jmp_en) begin
        n_checks++; if (if_pc !== exp_pc || if_instr !== mem_word(exp_pc)) begin n_fail++; $display("FAIL rnd_order@%0d: got pc=%h ins=%h want pc=%h ins=%h", c, if_pc, if_instr, exp_pc, mem_word(exp_pc)); end
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      if (jmp_en) exp_pc = jmp_target;
      prev_jmp  = jmp_en;
      prev_hold = if_valid && stall && !jmp_en;
      prev_pc   = if_pc;
      prev_ins  = if_instr;
      prev_out  = imem_req && !imem_ack;
      prev_addr = imem_addr;
    end
    stall = 1'b0;
    n_checks++; if (consumed < 100) begin n_fail++; $display("FAIL rnd_progress: got %0d consumed want >= 100", consumed); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_jump_wait();
    test_jump_ack();
    test_wrap();
    test_reset_mid();
`ifdef FETCH_HALT_EN
    test_halt();
`else
    test_halt_word_plain();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
